fir_out_decim_fifo: RTL and testbench

- Downstream neighbour of the pipelined 17-tap FIR.
- Consumes the FIR output (ValidOut and S4.12 FilterOut) and keeps every DECIM-th valid sample.
- Requantizes each kept sample to OUT_W bits with round-half-up and saturation, then buffers it in a synchronous FIFO.
- Presents the FIFO contents on a valid/ready interface. The FIR has no backpressure, so overflow is detected and flagged, never stalled.

---
 rtl/fir_pkg.sv | 41 ++++
 rtl/fir_sync_fifo.sv | 71 +++++++
 rtl/fir_out_decim_fifo.sv | 127 ++++++++++++
 tb/tb_fir_out_decim_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath and its downstream requantizers.
//   FIR_DATA_W / FIR_FRAC_W : FIR output sample format (S4.12)
//   FIR_IN_W                : FIR input sample width
//   round_shift()           : arithmetic right shift with round-half-up, unclamped
//   sat_round()             : round_shift() clamped to a signed out_w-bit range
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_FRAC_W = 12;
    localparam int FIR_IN_W   = 14;

    // Result is wide enough that the +1 rounding carry can never wrap.
    function automatic int round_shift(input logic [FIR_DATA_W-1:0] value, input int shift);
        int v;
        int r;
        v = int'($signed(value));
        r = v >>> shift;
        if (shift > 0) begin
            // Add the bit just below the new LSB: round half up.
            r = r + ((v >>> (shift - 1)) & 1);
        end
        return r;
    endfunction

    function automatic logic [FIR_DATA_W-1:0] sat_round(input logic [FIR_DATA_W-1:0] value,
                                                        input int shift, input int out_w);
        int r;
        int hi;
        int lo;
        r  = round_shift(value, shift);
        hi = (1 <<< (out_w - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r[FIR_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, i_rst         : clock, synchronous active-high reset (clears pointers, count, storage)
//   push_i, wdata_i    : write request and data
//   pop_i              : read request (ignored while empty)
//   rdata_o            : entry at the read pointer (show-ahead)
//   empty_o            : no entries held
//   count_o            : current occupancy, 0..DEPTH
//   drop_o             : push_i was refused because the FIFO was full and nothing was popped
module fir_sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full, pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok = push_i && (!full || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_out_decim_fifo.sv
// FIR output decimator, requantizer and output buffer.
// Keeps every DECIM-th valid FIR sample, rounds/saturates it from S4.12 to S4.(OUT_W-4),
// and queues it in a show-ahead FIFO read over valid/ready. The FIR cannot be stalled,
// so a kept sample arriving at a full FIFO is dropped and flagged.
//   clk, i_rst          : clock, synchronous active-high reset
//   i_valid, i_data     : FIR ValidOut / FilterOut (S4.12)
//   o_data, o_valid     : head-of-FIFO sample, FIFO non-empty
//   i_ready             : consumer accepts o_data when o_valid && i_ready
//   o_level             : FIFO occupancy
//   o_overflow          : sticky drop flag, cleared by i_ovf_clr (a new drop wins)
//   o_sat_cnt           : count of clamped kept samples, only with FIR_OUT_SAT_CNT_EN defined
module fir_out_decim_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DECIM      = 2,
    parameter int unsigned OUT_W      = 12,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic [FIR_DATA_W-1:0]         i_data,
    output logic [OUT_W-1:0]              o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    input  logic                          i_ovf_clr
`ifdef FIR_OUT_SAT_CNT_EN
    ,
    output logic [15:0]                   o_sat_cnt
`endif
);

    localparam int SH   = FIR_DATA_W - int'(OUT_W);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0]  phase_q, phase_d;
    logic             keep;
    logic [OUT_W-1:0] q_data_q, q_data_d;
    logic             q_valid_q;
    logic             overflow_q, overflow_d;
    logic             fifo_empty, fifo_drop;

    always_comb begin
        keep     = i_valid && (phase_q == '0);
        phase_d  = phase_q;
        q_data_d = OUT_W'(sat_round(i_data, SH, int'(OUT_W)));
        if (i_valid) begin
            phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end else if (i_ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            phase_q    <= '0;
            q_data_q   <= '0;
            q_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            q_valid_q  <= keep;
            overflow_q <= overflow_d;
            if (keep) begin
                q_data_q <= q_data_d;
            end
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (i_rst),
        .push_i  (q_valid_q),
        .wdata_i (q_data_q),
        .pop_i   (i_ready),
        .rdata_o (o_data),
        .empty_o (fifo_empty),
        .count_o (o_level),
        .drop_o  (fifo_drop)
    );

    assign o_valid    = !fifo_empty;
    assign o_overflow = overflow_q;

`ifdef FIR_OUT_SAT_CNT_EN
    localparam int SAT_MAX = (1 <<< (int'(OUT_W) - 1)) - 1;
    localparam int SAT_MIN = -SAT_MAX - 1;

    logic [15:0] sat_cnt_q, sat_cnt_d;
    int          raw;
    logic        clip;

    always_comb begin
        raw       = round_shift(i_data, SH);
        clip      = (raw > SAT_MAX) || (raw < SAT_MIN);
        sat_cnt_d = sat_cnt_q;
        if (i_ovf_clr) begin
            sat_cnt_d = '0;
        end else if (keep && clip && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// Directed bench for fir_out_decim_fifo. Two instances: dut2 (DECIM=2) and dut1 (DECIM=1),
// both OUT_W=12, FIFO_DEPTH=8. Expected output samples are queued when stimulus is driven
// and compared whenever a DUT handshake (o_valid && i_ready) is seen.
module tb_fir_out_decim_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        v1, r1, c1, v2, r2, c2;
    logic [15:0] d1, d2;
    logic [11:0] od1, od2;
    logic        ov1, ov2, oo1, oo2;
    logic [3:0]  ol1, ol2;
`ifdef FIR_OUT_SAT_CNT_EN
    logic [15:0] sc1, sc2;
`endif

    int checks = 0;
    int errors = 0;
    logic [11:0] q1[$];
    logic [11:0] q2[$];

    always #5 clk = ~clk;

    fir_out_decim_fifo #(.DECIM(1), .OUT_W(12), .FIFO_DEPTH(8)) dut1 (
        .clk        (clk),
        .i_rst      (rst),
        .i_valid    (v1),
        .i_data     (d1),
        .o_data     (od1),
        .o_valid    (ov1),
        .i_ready    (r1),
        .o_level    (ol1),
        .o_overflow (oo1),
        .i_ovf_clr  (c1)
`ifdef FIR_OUT_SAT_CNT_EN
        ,
        .o_sat_cnt  (sc1)
`endif
    );

    fir_out_decim_fifo #(.DECIM(2), .OUT_W(12), .FIFO_DEPTH(8)) dut2 (
        .clk        (clk),
        .i_rst      (rst),
        .i_valid    (v2),
        .i_data     (d2),
        .o_data     (od2),
        .o_valid    (ov2),
        .i_ready    (r2),
        .o_level    (ol2),
        .o_overflow (oo2),
        .i_ovf_clr  (c2)
`ifdef FIR_OUT_SAT_CNT_EN
        ,
        .o_sat_cnt  (sc2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs set: score any handshake about to happen, then advance.
    task automatic cyc();
        logic [11:0] e;
        if (ov1 && r1) begin
            if (q1.size() == 0) check("dut1 unexpected output", 32'(od1), 32'hFFFF_FFFF);
            else begin
                e = q1.pop_front();
                check("dut1 data", 32'(od1), 32'(e));
            end
        end
        if (ov2 && r2) begin
            if (q2.size() == 0) check("dut2 unexpected output", 32'(od2), 32'hFFFF_FFFF);
            else begin
                e = q2.pop_front();
                check("dut2 data", 32'(od2), 32'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [15:0] rnd_in  [6] = '{16'h0007, 16'h0008, 16'hFFF8, 16'hFFF7, 16'h7FF8, 16'h8000};
    logic [11:0] rnd_exp [6] = '{12'h000, 12'h001, 12'h000, 12'hFFF, 12'h7FF, 12'h800};

    initial begin
        rst = 1'b1;
        v1 = 1'b1; v2 = 1'b1; d1 = 16'h1234; d2 = 16'h1234;
        r1 = 1'b0; r2 = 1'b0; c1 = 1'b0; c2 = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with valid input: nothing enters
        for (int i = 0; i < 3; i++) begin
            check("rst ov1", 32'(ov1), 0);
            check("rst ol1", 32'(ol1), 0);
            check("rst oo1", 32'(oo1), 0);
            check("rst od1", 32'(od1), 0);
            check("rst ov2", 32'(ov2), 0);
            check("rst ol2", 32'(ol2), 0);
            cyc();
        end
        rst = 1'b0; v1 = 1'b0; v2 = 1'b0;
        cyc();
        cyc();
        check("post-rst ol1", 32'(ol1), 0);
        check("post-rst ol2", 32'(ol2), 0);

        // Decimation and latency on dut2
        r2 = 1'b1;
        v2 = 1'b1; d2 = 16'h1000; q2.push_back(12'h100);
        cyc();
        check("lat ov2 after 1", 32'(ov2), 0);
        d2 = 16'h2000;
        cyc();
        check("lat ov2 after 2", 32'(ov2), 1);
        check("lat od2 head", 32'(od2), 32'h100);
        d2 = 16'h3000; q2.push_back(12'h300);
        cyc();
        d2 = 16'h4000;
        cyc();
        v2 = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("decim drained", 32'(q2.size()), 0);
        check("decim ol2", 32'(ol2), 0);

        // Rounding and saturation on dut1
        r1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v1 = 1'b1; d1 = rnd_in[i]; q1.push_back(rnd_exp[i]);
            cyc();
        end
        v1 = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("round drained", 32'(q1.size()), 0);
`ifdef FIR_OUT_SAT_CNT_EN
        check("sat cnt", 32'(sc1), 1);
`endif

        // Overflow: 10 samples into a stalled 8-entry FIFO
        r1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            v1 = 1'b1; d1 = 16'(i << 4);
            if (i <= 8) q1.push_back(12'(i));
            cyc();
        end
        v1 = 1'b0;
        cyc();
        cyc();
        check("ovf level", 32'(ol1), 8);
        check("ovf flag", 32'(oo1), 1);
        check("ovf head", 32'(od1), 1);
        r1 = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check("ovf drained", 32'(q1.size()), 0);
        check("ovf drained level", 32'(ol1), 0);
        check("ovf sticky", 32'(oo1), 1);
        c1 = 1'b1;
        cyc();
        c1 = 1'b0;
        check("ovf cleared", 32'(oo1), 0);

        // Full FIFO with simultaneous push and pop
        r1 = 1'b0;
        for (int i = 17; i <= 25; i++) begin
            v1 = 1'b1; d1 = 16'(i << 4); q1.push_back(12'(i));
            cyc();
        end
        v1 = 1'b0; r1 = 1'b1;
        cyc();
        r1 = 1'b0;
        check("full pp level", 32'(ol1), 8);
        check("full pp no ovf", 32'(oo1), 0);
        check("full pp head", 32'(od1), 32'h12);
        r1 = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check("full pp drained", 32'(q1.size()), 0);
        check("full pp level 0", 32'(ol1), 0);

        // Reset mid-stream on dut2 with phase left at 1
        r2 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            v2 = 1'b1; d2 = 16'h1000;
            cyc();
        end
        v2 = 1'b0;
        cyc();
        cyc();
        check("mid level 5", 32'(ol2), 5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid rst ol2", 32'(ol2), 0);
        check("mid rst ov2", 32'(ov2), 0);
        check("mid rst od2", 32'(od2), 0);
        r2 = 1'b1;
        v2 = 1'b1; d2 = 16'h5000; q2.push_back(12'h500);
        cyc();
        v2 = 1'b0;
        cyc();
        check("mid first kept", 32'(ov2), 1);
        check("mid first data", 32'(od2), 32'h500);
        for (int i = 0; i < 4; i++) cyc();
        check("final q1 empty", 32'(q1.size()), 0);
        check("final q2 empty", 32'(q2.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
